lsu_align_ctrl: RTL
===================

// Module: lsu_align_ctrl
// PURPOSE
//  MEM-stage load/store sequencer that sits between the EX/MEM pipeline register and data_memory.
//  Aligned accesses are passed to memory unchanged, as one access.
//  Misaligned LH/LHU/LW/SH/SW are split into per-byte LBU/SB accesses, one per cycle.
//  Load results are reassembled and sign/zero-extended. The pipeline stalls while busy.
// PARAMETERS
//  SPLIT_EN  1   1: split misaligned accesses; 0: misaligned access -> err_o, no memory access
//  CNT_W     16  width of the saturating misaligned-access counter
// PORTS
//  clk             in   1      clock
//  rst_n           in   1      asynchronous active-low reset
//  req_valid_i     in   1      request present (accepted only when req_ready_o=1)
//  req_we_i        in   1      1=store, 0=load
//  req_funct3_i    in   3      RV32I load/store funct3
//  req_addr_i      in   32     byte address
//  req_wdata_i     in   32     store data
//  req_ready_o     out  1      1 only in IDLE
//  busy_o          out  1      ~req_ready_o; pipeline stall
//  done_o          out  1      1-cycle completion pulse
//  err_o           out  1      valid with done_o: illegal funct3, or misaligned with SPLIT_EN=0
//  rdata_o         out  32     load result, valid with done_o; 0 for stores and errors
//  misalign_cnt_o  out  CNT_W  count of split accesses, saturates at all-ones
//  mem_addr_o      out  32     to data_memory addr_i
//  mem_wdata_o     out  32     to data_memory write_data_i
//  mem_read_en_o   out  1      to data_memory read_en_i
//  mem_write_en_o  out  1      to data_memory write_en_i
//  mem_funct3_o    out  3      to data_memory funct3_i
//  mem_rdata_i     in   32     from data_memory read_data_o (combinational read)
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 except req_ready_o=1; misalign_cnt_o=0.
//  Reset mid-sequence aborts to IDLE. Bytes already written stay written; no done_o is issued.
//  States: IDLE -> ACCESS -> DONE -> IDLE; IDLE -> DONE directly for error requests.
//  IDLE: on req_valid_i, latch we/funct3/addr/wdata and set byte counter k=0.
//    Legal funct3: loads 000/001/010/100/101; stores 000/001/010. Anything else is an error.
//    Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Byte accesses never misalign.
//    Count N = 1 if aligned, 2 if split half, 4 if split word.
//  ACCESS (N cycles, k=0..N-1), exactly one mem enable high per cycle:
//    aligned: mem_addr=addr, mem_funct3=funct3, mem_wdata=wdata; load captures mem_rdata_i.
//    split load: mem_funct3=LBU(100), mem_addr=addr+k (mod 2^32); capture mem_rdata_i[7:0] into byte k.
//    split store: mem_funct3=SB(000), mem_addr=addr+k, mem_wdata={24'b0, wdata[8k+7:8k]}.
//    After k=N-1 go to DONE.
//  DONE (1 cycle): done_o=1; then return to IDLE. A new request can be accepted the following cycle.
//    Split LH: rdata = sign-extend of bit 15. Split LHU: zero-extend. Aligned: data as captured.
//  Error request: goes straight to DONE with err_o=1 and rdata_o=0. No mem enable is ever raised.
//  Latency from the acceptance edge: done_o is high N+1 cycles later; errors are 1 cycle later.
//  Outside ACCESS: mem_read_en_o=mem_write_en_o=0; mem_addr/wdata/funct3 held at 0.
//  rdata_o/err_o are 0 whenever done_o=0.
//  misalign_cnt_o increments on acceptance of each split request; it never wraps.
//  All outputs are registered, except that the mem_* outputs decode from state/k registers.
// TESTING
//  1. Aligned LW 0x100, mem=0x11223344 -> one read, funct3=010; done_o 2 cycles after accept; rdata 0x11223344.
//  2. SW 0xDEADBEEF @0x102 -> four SB, one per cycle: EF@102, BE@103, AD@104, DE@105.
//     done_o 5 cycles after accept; misalign_cnt_o=1.
//  3. LH @0x101, bytes 0x101=0x34, 0x102=0x80 -> two LBU; rdata 0xFFFF8034.
//     LHU at the same address -> rdata 0x00008034.
//  4. Load funct3=011 -> done_o next cycle with err_o=1, rdata 0; enables never asserted.
//     SPLIT_EN=0 with LW @0x1 gives the same response.
//  5. LW @0xFFFFFFFE -> byte addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001 (wrap).
//  6. rst_n low during 2nd byte of split SW -> enables 0 immediately; no done_o; req_ready_o=1 after release.

Source files
------------

// File: rtl/lsu_align_ctrl_if.sv
// Request/response and data-memory bundle for the MEM-stage load/store sequencer.
// The master side is the pipeline plus data_memory; the slave side is the sequencer.
interface lsu_align_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             req_valid_i;
    logic             req_we_i;
    logic [2:0]       req_funct3_i;
    logic [31:0]      req_addr_i;
    logic [31:0]      req_wdata_i;
    logic             req_ready_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [31:0]      rdata_o;
    logic [CNT_W-1:0] misalign_cnt_o;
    logic [31:0]      mem_addr_o;
    logic [31:0]      mem_wdata_o;
    logic             mem_read_en_o;
    logic             mem_write_en_o;
    logic [2:0]       mem_funct3_o;
    logic [31:0]      mem_rdata_i;

    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        output mem_rdata_i,
        input  req_ready_o, busy_o, done_o, err_o, rdata_o, misalign_cnt_o,
        input  mem_addr_o, mem_wdata_o, mem_read_en_o, mem_write_en_o, mem_funct3_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        input  mem_rdata_i,
        output req_ready_o, busy_o, done_o, err_o, rdata_o, misalign_cnt_o,
        output mem_addr_o, mem_wdata_o, mem_read_en_o, mem_write_en_o, mem_funct3_o
    );
endinterface

// File: rtl/lsu_align_ctrl.sv
// MEM-stage load/store sequencer: passes aligned accesses through and splits
// misaligned halves/words into byte accesses, reassembling load data.
module lsu_align_ctrl #(
    parameter bit SPLIT_EN = 1'b1,
    parameter int CNT_W    = 16
) (
    input logic            clk,
    input logic            rst_n,
    lsu_align_ctrl_if.slave bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [1:0]       state_q, state_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [1:0]       k_q, k_d;
    logic             split_q, split_d;
    logic [31:0]      buf_q, buf_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        legal;
    logic        misal;
    logic        in_err;
    logic        in_split;
    logic [1:0]  k_last;
    logic [31:0] wsh;
    logic [31:0] asm_data;
    logic [31:0] result;

    always_comb begin
        legal = 1'b0;
        unique case (bus.req_funct3_i)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = ~bus.req_we_i;
            default:          legal = 1'b0;
        endcase
        misal = ((bus.req_funct3_i[1:0] == 2'b01) & bus.req_addr_i[0])
              | ((bus.req_funct3_i[1:0] == 2'b10) & (|bus.req_addr_i[1:0]));
        in_split = legal & misal & SPLIT_EN;
        in_err   = ~legal | (misal & ~SPLIT_EN);
    end

    assign k_last = ~split_q ? 2'd0 : ((f3_q[1:0] == 2'b01) ? 2'd1 : 2'd3);
    assign wsh    = wdata_q >> {k_q, 3'b000};

    // Memory side decodes straight from state/k so each byte lands in its own cycle.
    always_comb begin
        bus.mem_addr_o     = 32'd0;
        bus.mem_wdata_o    = 32'd0;
        bus.mem_funct3_o   = 3'd0;
        bus.mem_read_en_o  = 1'b0;
        bus.mem_write_en_o = 1'b0;
        if (state_q == S_ACCESS) begin
            bus.mem_read_en_o  = ~we_q;
            bus.mem_write_en_o = we_q;
            if (split_q) begin
                bus.mem_addr_o   = addr_q + {30'd0, k_q};
                bus.mem_funct3_o = we_q ? F3_B : F3_BU;
                bus.mem_wdata_o  = {24'd0, wsh[7:0]};
            end else begin
                bus.mem_addr_o   = addr_q;
                bus.mem_funct3_o = f3_q;
                bus.mem_wdata_o  = wdata_q;
            end
        end
    end

    always_comb begin
        asm_data = buf_q;
        asm_data[{k_q, 3'b000} +: 8] = bus.mem_rdata_i[7:0];
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        k_d     = k_q;
        split_d = split_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        result  = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    we_d    = bus.req_we_i;
                    f3_d    = bus.req_funct3_i;
                    addr_d  = bus.req_addr_i;
                    wdata_d = bus.req_wdata_i;
                    k_d     = 2'd0;
                    split_d = in_split;
                    buf_d   = 32'd0;
                    if (in_err) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else begin
                        state_d = S_ACCESS;
                    end
                    if (in_split && !(&cnt_q))
                        cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ACCESS: begin
                if (!we_q)
                    buf_d = split_q ? asm_data : bus.mem_rdata_i;
                if (!split_q)
                    result = buf_d;
                else if (f3_q == F3_H)
                    result = {{16{buf_d[15]}}, buf_d[15:0]};
                else if (f3_q == F3_HU)
                    result = {16'd0, buf_d[15:0]};
                else
                    result = buf_d;
                if (k_q == k_last) begin
                    state_d = S_DONE;
                    rdata_d = we_q ? 32'd0 : result;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
                rdata_d = 32'd0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            k_q     <= 2'd0;
            split_q <= 1'b0;
            buf_q   <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            k_q     <= k_d;
            split_q <= split_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req_ready_o    = (state_q == S_IDLE);
    assign bus.busy_o         = (state_q != S_IDLE);
    assign bus.done_o         = (state_q == S_DONE);
    assign bus.err_o          = err_q;
    assign bus.rdata_o        = rdata_q;
    assign bus.misalign_cnt_o = cnt_q;

endmodule
